// File: rtl/alsu_pkg.sv
// Shared types and constants for the ALSU seven-segment result display.
// Optional feature macro used by alsu_seg_scanner: SEG_LEADING_ZERO_BLANK_EN.
package alsu_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_SHIFTS = 6;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alsu_bcd_shift.sv
// Iterative shift-add-3 binary-to-BCD converter for a 6-bit magnitude (0..63).
// Loads on start, shifts once per cycle, and pulses done after the last shift.
module alsu_bcd_shift
    import alsu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] mag,
    output logic       busy,
    output logic       done,
    output logic [3:0] ones,
    output logic [3:0] tens
);

    logic [5:0]  bin;
    logic [7:0]  bcd;
    logic [2:0]  cnt;
    logic [3:0]  adj_ones;
    logic [3:0]  adj_tens;
    logic [13:0] shifted;

    // Correct each BCD digit before the shift so it carries properly into the next
    always_comb begin
        adj_ones = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        adj_tens = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        shifted  = {adj_tens, adj_ones, bin} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin  <= mag;
                bcd  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                bcd <= shifted[13:6];
                bin <= shifted[5:0];
                cnt <= cnt + 3'd1;
                if (cnt == 3'(BCD_SHIFTS - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign ones = bcd[3:0];
    assign tens = bcd[7:4];

endmodule

// File: rtl/alsu_seg_scanner.sv
// Captures an ALSU result, converts it to BCD and multiplexes it onto a 4-digit display.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module alsu_seg_scanner
    import alsu_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] value,
    input  logic       signed_mode,
    output logic       busy,
    output logic       done,
    output logic [3:0] anode,
    output logic [6:0] cathode
);

    localparam int             PW       = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(REFRESH_DIV - 1);

    state_t      state;
    logic        neg_q;
    logic        start;
    logic        sign_in;
    logic [5:0]  mag;
    logic        bcd_busy;
    logic        bcd_done;
    logic [3:0]  bcd_ones;
    logic [3:0]  bcd_tens;

    logic [3:0]  bank_ones;
    logic [3:0]  bank_tens;
    logic        bank_neg;
    logic        valid;

    logic        bank_wr;
    logic [3:0]  ones_nxt;
    logic [3:0]  tens_nxt;
    logic        neg_nxt;
    logic        valid_nxt;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nxt;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;
    logic [6:0]  seg_nxt;
    logic [3:0]  anode_nxt;
    logic [6:0]  cathode_nxt;

    // Handshake: load is a one-cycle request honoured only while busy is low;
    // requests seen while busy are dropped, and done marks the bank update.
    assign start   = (state == IDLE) && load;
    assign sign_in = value[5] & signed_mode;
    assign mag     = sign_in ? (~value + 6'd1) : value;
    assign bank_wr = (state == CONV) && bcd_done;

    alsu_bcd_shift u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mag   (mag),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .ones  (bcd_ones),
        .tens  (bcd_tens)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            neg_q     <= 1'b0;
            bank_ones <= '0;
            bank_tens <= '0;
            bank_neg  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= CONV;
                        busy  <= 1'b1;
                        neg_q <= sign_in;
                    end
                end
                CONV: begin
                    if (bcd_done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        bank_ones <= bcd_ones;
                        bank_tens <= bcd_tens;
                        bank_neg  <= neg_q;
                        valid     <= 1'b1;
                    end else if (!bcd_busy) begin
                        // Converter idle without a result: recover instead of hanging
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are computed from next-cycle bank/index so anode and cathode move together
    always_comb begin
        ones_nxt  = bank_wr ? bcd_ones : bank_ones;
        tens_nxt  = bank_wr ? bcd_tens : bank_tens;
        neg_nxt   = bank_wr ? neg_q    : bank_neg;
        valid_nxt = valid | bank_wr;

        pre_nxt = pre;
        idx_nxt = idx;
        if (!valid) begin
            pre_nxt = '0;
            idx_nxt = '0;
        end else if (pre == PRE_LAST) begin
            pre_nxt = '0;
            idx_nxt = idx + 2'd1;
        end else begin
            pre_nxt = pre + 1'b1;
        end

        case (idx_nxt)
            2'd0: seg_nxt = seg_encode(ones_nxt);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            2'd1: seg_nxt = (tens_nxt == 4'd0) ? SEG_BLANK : seg_encode(tens_nxt);
            2'd2: seg_nxt = SEG_BLANK;
            default: seg_nxt = neg_nxt ? SEG_MINUS : SEG_BLANK;
`else
            2'd1: seg_nxt = seg_encode(tens_nxt);
            2'd2: seg_nxt = SEG_0;
            default: seg_nxt = neg_nxt ? SEG_MINUS : SEG_0;
`endif
        endcase

        anode_nxt   = valid_nxt ? (4'b0001 << idx_nxt) : 4'b0000;
        cathode_nxt = valid_nxt ? seg_nxt : SEG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre     <= '0;
            idx     <= '0;
            anode   <= 4'b0000;
            cathode <= SEG_BLANK;
        end else begin
            pre     <= pre_nxt;
            idx     <= idx_nxt;
            anode   <= anode_nxt;
            cathode <= cathode_nxt;
        end
    end

endmodule

// File: tb/tb_alsu_seg_scanner.sv
// Directed bench for alsu_seg_scanner with REFRESH_DIV=4.
// Honours SEG_LEADING_ZERO_BLANK_EN when choosing expected leading-digit codes.
module tb_alsu_seg_scanner;

    localparam logic [6:0] C0    = 7'b1000000;
    localparam logic [6:0] C1    = 7'b1111001;
    localparam logic [6:0] C2    = 7'b0100100;
    localparam logic [6:0] C3    = 7'b0110000;
    localparam logic [6:0] C4    = 7'b0011001;
    localparam logic [6:0] C5    = 7'b0010010;
    localparam logic [6:0] C6    = 7'b0000010;
    localparam logic [6:0] C7    = 7'b1111000;
    localparam logic [6:0] C9    = 7'b0010000;
    localparam logic [6:0] CMIN  = 7'b0111111;
    localparam logic [6:0] CBLK  = 7'b1111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] CLEAD = CBLK;
`else
    localparam logic [6:0] CLEAD = C0;
`endif

    logic       clk;
    logic       rst;
    logic       load;
    logic [5:0] value;
    logic       signed_mode;
    logic       busy;
    logic       done;
    logic [3:0] anode;
    logic [6:0] cathode;

    int n_tests;
    int n_fail;
    int n_done;
    logic [6:0] exp_q[$];

    alsu_seg_scanner #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .anode       (anode),
        .cathode     (cathode)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves load low at posedge E0 + 1
    task automatic do_load(input logic [5:0] v, input logic s);
        @(negedge clk);
        load        = 1'b1;
        value       = v;
        signed_mode = s;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic run_conv(input string tag, input logic [5:0] v, input logic s);
        do_load(v, s);
        wait_done(tag);
    endtask

    // Scoreboard: pops four expected cathode codes, digit 0 first
    task automatic scan_digits(input string tag);
        logic [3:0] target;
        logic [6:0] exp_c;
        for (int d = 0; d < 4; d++) begin
            target = 4'b0001 << d;
            for (int i = 0; i < 24; i++) begin
                @(posedge clk);
                #1;
                if (anode === target) break;
            end
            exp_c = exp_q.pop_front();
            check($sformatf("%s_an%0d", tag, d), {28'd0, anode}, {28'd0, target});
            check($sformatf("%s_ca%0d", tag, d), {25'd0, cathode}, {25'd0, exp_c});
        end
    endtask

    task automatic count_done(input int cycles);
        n_done = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        load        = 1'b0;
        value       = '0;
        signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_anode", {28'd0, anode}, 32'h0);
        check("rst_cathode", {25'd0, cathode}, 32'h7F);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_anode", {28'd0, anode}, 32'h0);

        // 45 unsigned: exact cycle timing
        do_load(6'd45, 1'b0);
        check("c45_busy_e0", {31'd0, busy}, 32'd1);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("c45_busy_e%0d", e), {31'd0, busy}, 32'd1);
            check($sformatf("c45_done_e%0d", e), {31'd0, done}, 32'd0);
            check($sformatf("c45_anode_e%0d", e), {28'd0, anode}, 32'h0);
        end
        @(posedge clk);
        #1;
        check("c45_busy_e7", {31'd0, busy}, 32'd0);
        check("c45_done_e7", {31'd0, done}, 32'd1);
        check("c45_anode_e7", {28'd0, anode}, 32'h1);
        check("c45_cath_e7", {25'd0, cathode}, {25'd0, C5});
        @(posedge clk);
        #1;
        check("c45_done_e8", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("c45_anode_e11", {28'd0, anode}, 32'h2);
        check("c45_cath_e11", {25'd0, cathode}, {25'd0, C4});
        exp_q.push_back(C5); exp_q.push_back(C4); exp_q.push_back(CLEAD); exp_q.push_back(CLEAD);
        scan_digits("c45");

        // -5 signed
        run_conv("m5", 6'b111011, 1'b1);
        exp_q.push_back(C5); exp_q.push_back(CLEAD); exp_q.push_back(CLEAD); exp_q.push_back(CMIN);
        scan_digits("m5");

        // -32 signed: most negative value
        run_conv("m32", 6'b100000, 1'b1);
        exp_q.push_back(C2); exp_q.push_back(C3); exp_q.push_back(CLEAD); exp_q.push_back(CMIN);
        scan_digits("m32");

        // 63 unsigned: largest value, bit 5 set without sign
        run_conv("u63", 6'd63, 1'b0);
        exp_q.push_back(C3); exp_q.push_back(C6); exp_q.push_back(CLEAD); exp_q.push_back(CLEAD);
        scan_digits("u63");

        // 12 then 63 one cycle later: second load dropped
        do_load(6'd12, 1'b0);
        do_load(6'd63, 1'b0);
        count_done(20);
        check("drop_done_count", n_done, 32'd1);
        check("drop_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(C2); exp_q.push_back(C1); exp_q.push_back(CLEAD); exp_q.push_back(CLEAD);
        scan_digits("drop");

        // Reset at E3 aborts the conversion
        do_load(6'd33, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_anode", {28'd0, anode}, 32'h0);
        check("abort_cathode", {25'd0, cathode}, 32'h7F);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(12);
        check("abort_no_done", n_done, 32'd0);
        check("abort_anode_after", {28'd0, anode}, 32'h0);
        run_conv("n9", 6'd9, 1'b0);
        exp_q.push_back(C9); exp_q.push_back(CLEAD); exp_q.push_back(CLEAD); exp_q.push_back(CLEAD);
        scan_digits("n9");

        // 7 unsigned: zero tens digit
        run_conv("u7", 6'd7, 1'b0);
        exp_q.push_back(C7); exp_q.push_back(CLEAD); exp_q.push_back(CLEAD); exp_q.push_back(CLEAD);
        scan_digits("u7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
